// File: rtl/alu_pkg.sv
// Shared definitions for the 32-bit sequencer around the 16-bit ALU.
// Latency: n/a (constants, types and a helper only).
// Backpressure: n/a.
package alu_pkg;

  // Default ALU half width; commands are twice this wide.
  localparam int W_HALF_DEF = 16;

  // ALU Control encoding. The arithmetic ops share bit 1.
  localparam logic [1:0] OP_LOGIC0 = 2'b00;
  localparam logic [1:0] OP_LOGIC1 = 2'b01;
  localparam logic [1:0] OP_ADD    = 2'b10;
  localparam logic [1:0] OP_SUB    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Arithmetic ops need the carry/borrow fix-up pass on the high half.
  function automatic logic is_arith(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_seq32.sv
// Purpose: runs one 32-bit command through an external 16-bit ALU, low half, high half, then a carry/borrow fix-up pass.
// Latency: OutValid in the 4th cycle after the accept cycle for ADD/SUB, the 3rd for logic ops.
// Backpressure: holds the result in DONE until OutReady; InReady stays low until the output handshake completes.
//
// Ports:
//   Clk, nRst               clock, asynchronous active-low reset
//   InValid/InReady         command handshake; InOp, InA, InB carry the command
//   AluControl/AluA/AluB    drive the external ALU; AluResult/AluCB return from it
//   OutValid/OutReady       result handshake; OutResult, OutCB carry the result
module alu_seq32
  import alu_pkg::*;
#(
  parameter int W_HALF = W_HALF_DEF
) (
  input  logic                  Clk,
  input  logic                  nRst,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [1:0]            InOp,
  input  logic [2*W_HALF-1:0]   InA,
  input  logic [2*W_HALF-1:0]   InB,
  output logic [1:0]            AluControl,
  output logic [W_HALF-1:0]     AluA,
  output logic [W_HALF-1:0]     AluB,
  input  logic [W_HALF-1:0]     AluResult,
  input  logic                  AluCB,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [2*W_HALF-1:0]   OutResult,
  output logic                  OutCB
);

  state_t                state;
  logic [1:0]            op_q;
  logic [2*W_HALF-1:0]   a_q;
  logic [2*W_HALF-1:0]   b_q;
  logic [W_HALF-1:0]     res_lo;
  logic [W_HALF-1:0]     res_hi;
  logic                  cy;      // carry/borrow out of the low half
  logic                  cb_hi;   // carry/borrow out of the high half
  logic                  cb_fix;  // carry/borrow out of the fix-up pass

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state  <= ST_IDLE;
      op_q   <= OP_LOGIC0;
      a_q    <= '0;
      b_q    <= '0;
      res_lo <= '0;
      res_hi <= '0;
      cy     <= 1'b0;
      cb_hi  <= 1'b0;
      cb_fix <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (InValid) begin
            op_q   <= InOp;
            a_q    <= InA;
            b_q    <= InB;
            cb_fix <= 1'b0;
            state  <= ST_LO;
          end
        end
        ST_LO: begin
          res_lo <= AluResult;
          cy     <= AluCB;
          state  <= ST_HI;
        end
        ST_HI: begin
          res_hi <= AluResult;
          cb_hi  <= AluCB;
          state  <= is_arith(op_q) ? ST_FIX : ST_DONE;
        end
        ST_FIX: begin
          // High half re-run with the low-half carry/borrow as the B operand.
          res_hi <= AluResult;
          cb_fix <= AluCB;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          if (OutReady) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ALU inputs depend only on registered state, so AluResult settles within the cycle.
  always_comb begin
    AluControl = OP_LOGIC0;
    AluA       = '0;
    AluB       = '0;
    case (state)
      ST_LO: begin
        AluControl = op_q;
        AluA       = a_q[W_HALF-1:0];
        AluB       = b_q[W_HALF-1:0];
      end
      ST_HI: begin
        AluControl = op_q;
        AluA       = a_q[2*W_HALF-1:W_HALF];
        AluB       = b_q[2*W_HALF-1:W_HALF];
      end
      ST_FIX: begin
        AluControl = op_q;
        AluA       = res_hi;
        AluB       = {{(W_HALF-1){1'b0}}, cy};
      end
      default: ;
    endcase
  end

  // InReady is gated by nRst so a command cannot be taken during reset.
  assign InReady   = nRst && (state == ST_IDLE);
  assign OutValid  = (state == ST_DONE);
  // Result is only visible in DONE, so no partial result ever leaks out.
  assign OutResult = OutValid ? {res_hi, res_lo} : '0;
  // cb_hi and cb_fix are mutually exclusive, so OR gives the single final carry/borrow.
  assign OutCB     = OutValid && is_arith(op_q) && (cb_hi || cb_fix);

endmodule

// File: doc/alu_seq32.md
Name: alu_seq32

Overview:
Sequential 32-bit operation initiator for the team's combinational 16-bit ALU. Accepts one 32-bit command over a valid/ready handshake and drives the ALU's Control/A/B inputs one 16-bit half per cycle. The ALU's single 16-bit CB output is chained across halves by an extra carry/borrow fix-up pass. Returns the 32-bit result and final carry/borrow over a second valid/ready handshake.

Parameters:
W_HALF, 16, ALU data width; the command width is 2*W_HALF.

Ports:
Clk  in  1  rising-edge clock
nRst  in  1  asynchronous active-low reset
InValid  in  1  command valid
InReady  out  1  high in IDLE only; forced 0 while nRst low
InOp  in  2  ALU operation code; uses the same encoding as ALU Control
InA  in  32  operand A
InB  in  32  operand B
AluControl  out  2  drives ALU Control
AluA  out  16  drives ALU A
AluB  out  16  drives ALU B
AluResult  in  16  ALU nBitOut, combinational from AluControl/AluA/AluB
AluCB  in  1  ALU CB; carry for ADD, borrow for SUB
OutValid  out  1  result valid
OutReady  in  1  result accepted
OutResult  out  32  result
OutCB  out  1  final carry (ADD) or borrow (SUB); 0 for logic ops

Behaviour:
- Op codes: OP_ADD=2'b10 and OP_SUB=2'b11 are arithmetic. 2'b00 and 2'b01 are logic ops with no carry chaining.
- Reset (asynchronous, nRst low):
  - state=IDLE; OutValid=0; OutResult=0; OutCB=0.
  - Internal cy, cb_hi, cb_fix and captured operands = 0.
- ALU drive is registered-state based:
  - AluControl=op_q in LO, HI and FIX.
  - AluControl=2'b00 and AluA=AluB=0 in IDLE and DONE.
- FSM states: IDLE, LO, HI, FIX, DONE.
- IDLE: InReady=1. On InValid, capture InOp, InA and InB, then go to LO. With InValid low, stay in IDLE.
- LO:
  - Drive AluA=A_q[15:0], AluB=B_q[15:0].
  - At the edge, ResLo<=AluResult and cy<=AluCB, then go to HI.
- HI:
  - Drive AluA=A_q[31:16], AluB=B_q[31:16].
  - At the edge, ResHi<=AluResult and cb_hi<=AluCB.
  - Go to FIX if the op is arithmetic, else go to DONE.
- FIX:
  - Drive AluA=ResHi, AluB={15'b0,cy}. This is always executed for arithmetic ops, even when cy=0.
  - At the edge, ResHi<=AluResult and cb_fix<=AluCB, then go to DONE.
- DONE:
  - OutValid=1, OutResult={ResHi,ResLo}.
  - OutCB = arith ? (cb_hi|cb_fix) : 0. cb_hi and cb_fix are never both 1.
  - Hold all outputs stable until OutReady. On OutValid&&OutReady, go to IDLE.
- Latency from the accept edge: OutValid rises 4 cycles later for arithmetic ops and 3 cycles later for logic ops.
- Throughput: one command per 5 cycles (arith) or 4 cycles (logic) when OutReady is held high.
- Backpressure: OutReady low in DONE stalls indefinitely. InReady stays 0 until the cycle after the output handshake; there is no overlap between commands.
- InValid while busy is ignored; the command is not lost because InReady=0.
- Reset mid-operation aborts immediately. No partial result is ever presented.
- Wrap-around: results are modulo 2^32, with overflow reported only through OutCB.

Decomposition:
- Package alu_pkg: OP_ADD/OP_SUB/OP_LOGIC0/OP_LOGIC1 localparams, state enum (IDLE, LO, HI, FIX, DONE), W_HALF default.
- No sub-module. The ALU itself stays outside alu_seq32.
- The testbench instantiates the 16-bit ALU and wires it to the Alu* ports.

Test Plan:
- Reset: nRst low mid-FIX -> OutValid=0, OutResult=0, OutCB=0, InReady=1 once nRst is high; next command completes correctly.
- ADD 0x0000FFFF + 0x00000001 -> OutResult=0x00010000, OutCB=0, OutValid 4 cycles after accept.
- ADD 0xFFFFFFFF + 0x00000001 -> OutResult=0x00000000, OutCB=1 (cb_fix path).
- SUB 0x00010000 - 0x00000001 -> 0x0000FFFF, OutCB=0. SUB 0x00000000 - 0x00000001 -> 0xFFFFFFFF, OutCB=1.
- Logic op 2'b00 on 0xF0F0_1234 / 0x0FF0_FFFF -> result equals the ALU logic result per half, OutCB=0, OutValid 3 cycles after accept, FIX never entered.
- Backpressure: OutReady held low 10 cycles in DONE -> OutResult/OutCB stable, InReady=0, extra InValid pulses ignored. After OutReady: back-to-back commands each accepted exactly once.
